imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the pipelined RISC-V core.
- Sits between decode and execute. Takes the raw instruction plus an immediate-format select and produces the extended immediate one cycle later.
- Supports all RV32I/RV64I formats: I, S, B, U, J, plus shamt.
- Uses a 2-entry skid buffer so back-pressure from execute never drops or duplicates an instruction. Supports flush on branch mispredict.

Parameters:
- DATA_WIDTH, 32, output immediate width; legal values 32 or 64; extension always fills bits [DATA_WIDTH-1:32].
- IMM_WIDTH, 3, width of the format-select field.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- flush_i  in  1  synchronous kill of all buffered entries.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  block can accept an entry this cycle.
- instr_i  in  32  raw instruction.
- ImmSrc_i  in  IMM_WIDTH  format select.
- out_valid_o  out  1  ImmOp_o/err_o valid.
- out_ready_i  in  1  downstream accepts.
- ImmOp_o  out  DATA_WIDTH  extended immediate.
- err_o  out  1  ImmSrc_i was an unsupported encoding.

Behaviour:
- ImmSrc encoding, with s = instr[31] replicated to fill the upper bits:
  - 000 I: {s, instr[31:20]}
  - 001 S: {s, instr[31:25], instr[11:7]}
  - 010 B: {s, instr[7], instr[30:25], instr[11:8], 0}
  - 011 U: {s, instr[31:12], 12'b0}; bits above 31 are sign-filled for RV64
  - 100 J: {s, instr[19:12], instr[20], instr[30:21], 0}
  - 101 shamt: zero-extended instr[25:20] when DATA_WIDTH=64, instr[24:20] when 32
  - 110/111: ImmOp=0, err=1
- Decode is combinational on input. The decoded result plus err is what gets buffered.
- Storage: main register (slot0) and skid register (slot1), each with its own valid bit.
- Handshakes:
  - Input handshake occurs when in_valid_i && in_ready_o.
  - Output handshake occurs when out_valid_o && out_ready_i.
  - in_ready_o = !slot1_valid. It is registered, not a combinational function of out_ready_i.
- Outputs: out_valid_o = slot0_valid; ImmOp_o/err_o come from slot0.
- State per cycle (states EMPTY, ONE, FULL):
  - EMPTY + input: load slot0 → ONE.
  - ONE + input + output: reload slot0 → ONE.
  - ONE + input, no output: load slot1 → FULL.
  - ONE + output, no input: → EMPTY.
  - FULL + output: slot1 moves to slot0 → ONE. No input is possible in FULL.
  - FULL, no output: hold.
- Latency: 1 cycle input-to-output with no stall. Throughput is 1 per cycle while out_ready_i is held high.
- Ordering is strictly FIFO; never more than 2 entries.
- Output stability: while out_valid_o && !out_ready_i, ImmOp_o and err_o must not change.
- flush_i:
  - Next cycle both valid bits are 0 and in_ready_o is 1.
  - Any same-cycle input is discarded.
  - flush has priority over every handshake.
- Reset (rst_ni low): immediately out_valid_o=0, ImmOp_o=0, err_o=0, slot1_valid=0, in_ready_o=1.
  - This holds even mid-stall with FULL state.
  - The first accept is on the first rising edge after rst_ni deasserts.
- Data registers need not be cleared on flush; only valid bits. Data is cleared on reset.

Decomposition:
- Shared package imm_pkg:
  - imm_src_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT).
  - struct imm_entry_t {imm, err}.
  - Constant INSTR_WIDTH=32.
- Sub-module imm_decode: the purely combinational format decoder, parameterised on DATA_WIDTH. The top holds only the skid-buffer control and registers.

Test Plan:
- I/U/J decode, out_ready_i=1, DATA_WIDTH=32:
  - I 0xFFF00093 → ImmOp 0xFFFFFFFF.
  - U 0x123450B7 → 0x12345000.
  - J 0x001000EF → 0x00000800.
  - Each with out_valid_o exactly one cycle after accept.
- S/B decode:
  - S 0xFE20AE23 → 0xFFFFFFFC.
  - B 0xFE000EE3 → 0xFFFFFFFC.
  - ImmSrc 110 → ImmOp 0, err_o=1.
- Back-pressure:
  - Stream A, B, C back-to-back with out_ready_i=0 from cycle 1.
  - Required: A on output and stable, B in skid, in_ready_o=0, C held upstream.
  - Release out_ready_i → A, B, C delivered in order, no gaps or duplicates.
- Flush in FULL state plus same-cycle in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1, the flushed-cycle entry never appears.
- Async reset asserted mid-cycle while FULL → out_valid_o drops before the next clock edge, ImmOp_o=0, in_ready_o=1.
- DATA_WIDTH=64:
  - I 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
  - U 0x800000B7 → 0xFFFFFFFF80000000.
  - shamt with instr[25:20]=63 → 0x3F.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and constants for the registered immediate generator.
package imm_pkg;

  localparam int INSTR_WIDTH   = 32;
  // Decoder always builds the full RV64 view; narrower pipes keep the low bits.
  localparam int IMM_MAX_WIDTH = 64;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } fill_state_e;

  typedef struct packed {
    logic [IMM_MAX_WIDTH-1:0] imm;
    logic                     err;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-side and execute-side handshake bundle of the immediate generator.
// valid/ready: a transfer happens on a rising edge where both are high; a
// producer holding valid keeps its payload stable until that transfer.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [IMM_WIDTH-1:0]   imm_src;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  imm_op;
  logic                   err;

  modport master (
    output in_valid, instr, imm_src, out_ready,
    input  in_ready, out_valid, imm_op, err
  );

  modport slave (
    input  in_valid, instr, imm_src, out_ready,
    output in_ready, out_valid, imm_op, err
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder; unsupported selects flag err.
module imm_decode
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 3
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [IMM_WIDTH-1:0]   imm_src,
  output imm_entry_t             entry
);
  logic s;
  logic unused_opcode;

  assign s             = instr[31];
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    entry = '0;
    case (imm_src)
      IMM_WIDTH'(IMM_I):
        entry.imm = {{(IMM_MAX_WIDTH-12){s}}, instr[31:20]};
      IMM_WIDTH'(IMM_S):
        entry.imm = {{(IMM_MAX_WIDTH-12){s}}, instr[31:25], instr[11:7]};
      IMM_WIDTH'(IMM_B):
        entry.imm = {{(IMM_MAX_WIDTH-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_WIDTH'(IMM_U):
        entry.imm = {{(IMM_MAX_WIDTH-32){s}}, instr[31:12], 12'b0};
      IMM_WIDTH'(IMM_J):
        entry.imm = {{(IMM_MAX_WIDTH-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_WIDTH'(IMM_SHAMT): begin
        // RV64 shifts take a 6-bit amount, RV32 only 5 bits.
        if (DATA_WIDTH == 64) entry.imm = IMM_MAX_WIDTH'(instr[25:20]);
        else                  entry.imm = IMM_MAX_WIDTH'(instr[24:20]);
      end
      default: entry.err = 1'b1;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode feeds a two-slot skid buffer so
// execute back-pressure never drops or duplicates an instruction.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMM_WIDTH  = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  imm_gen_pipe_if.slave bus,
  output fill_state_e   dbg_state_o
);
  fill_state_e           state_q, state_d;
  imm_entry_t            dec;
  logic [DATA_WIDTH-1:0] slot0_imm, slot1_imm;
  logic                  slot0_err, slot1_err;
  logic                  in_ready, accept, deliver;
  logic                  load0, load1, shift;

  imm_decode #(.DATA_WIDTH(DATA_WIDTH), .IMM_WIDTH(IMM_WIDTH)) u_decode (
    .instr   (bus.instr),
    .imm_src (bus.imm_src),
    .entry   (dec)
  );

  if (DATA_WIDTH < IMM_MAX_WIDTH) begin : g_narrow
    logic unused_upper;
    assign unused_upper = ^dec.imm[IMM_MAX_WIDTH-1:DATA_WIDTH];
  end

  // Ready depends only on the skid slot, so it never combinationally follows out_ready.
  assign in_ready      = (state_q != ST_FULL);
  assign accept        = bus.in_valid && in_ready;
  assign deliver       = bus.out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.imm_op    = slot0_imm;
  assign bus.err       = slot0_err;
  assign dbg_state_o   = state_q;

  always_comb begin
    state_d = state_q;
    load0   = 1'b0;
    load1   = 1'b0;
    shift   = 1'b0;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          load0   = 1'b1;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          if (accept && deliver) begin
            load0 = 1'b1;
          end else if (accept) begin
            load1   = 1'b1;
            state_d = ST_FULL;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (deliver) begin
          shift   = 1'b1;
          state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_EMPTY;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot0_imm <= '0;
      slot0_err <= 1'b0;
      slot1_imm <= '0;
      slot1_err <= 1'b0;
    end else begin
      if (load0) begin
        slot0_imm <= dec.imm[DATA_WIDTH-1:0];
        slot0_err <= dec.err;
      end else if (shift) begin
        slot0_imm <= slot1_imm;
        slot0_err <= slot1_err;
      end
      if (load1) begin
        slot1_imm <= dec.imm[DATA_WIDTH-1:0];
        slot1_err <= dec.err;
      end
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: 32- and 64-bit instances, constant vectors,
// directed stall/flush/reset sequences and a random run against a queue model.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  typedef struct {
    int          dw;
    logic [2:0]  src;
    logic [31:0] instr;
    logic [63:0] imm;
    logic        err;
  } vec_t;

  localparam int NV = 12;

  logic        clk, rst_n, flush32, flush64;
  fill_state_e dbg32, dbg64;
  int          checks = 0;
  int          errors = 0;
  logic [64:0] exp32_q[$];
  logic [64:0] exp64_q[$];
  logic [64:0] got_q[$];
  logic        hold[2];
  logic [64:0] prev[2];
  vec_t        vecs[NV];

  imm_gen_pipe_if #(.DATA_WIDTH(32), .IMM_WIDTH(3)) bus32();
  imm_gen_pipe_if #(.DATA_WIDTH(64), .IMM_WIDTH(3)) bus64();

  imm_gen_pipe #(.DATA_WIDTH(32), .IMM_WIDTH(3)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush32), .bus(bus32), .dbg_state_o(dbg32)
  );
  imm_gen_pipe #(.DATA_WIDTH(64), .IMM_WIDTH(3)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush64), .bus(bus64), .dbg_state_o(dbg64)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference: immediates from field meaning, using signed arithmetic
  function automatic logic [64:0] ref_imm(input int dw, input logic [31:0] ins, input logic [2:0] src);
    longint v;
    logic   e;
    v = 0;
    e = 1'b0;
    case (src)
      3'd0: v = longint'($signed(ins)) >>> 20;
      3'd1: v = ((longint'($signed(ins)) >>> 20) & ~longint'(31)) | longint'(ins[11:7]);
      3'd2: v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
      3'd3: v = longint'($signed(ins & 32'hFFFF_F000));
      3'd4: v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
      3'd5: v = (dw == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: e = 1'b1;
    endcase
    if (dw == 32) v = v & longint'(32'hFFFF_FFFF);
    return {e, 64'(v)};
  endfunction

  function automatic int q_size(input int idx);
    return (idx == 0) ? exp32_q.size() : exp64_q.size();
  endfunction

  function automatic void q_push(input int idx, input logic [64:0] v);
    if (idx == 0) exp32_q.push_back(v);
    else          exp64_q.push_back(v);
  endfunction

  function automatic logic [64:0] q_pop(input int idx);
    if (idx == 0) return exp32_q.pop_front();
    return exp64_q.pop_front();
  endfunction

  function automatic void q_clear(input int idx);
    if (idx == 0) exp32_q.delete();
    else          exp64_q.delete();
  endfunction

  function automatic logic [64:0] out_of(input int dw);
    return (dw == 32) ? {bus32.err, 32'h0, bus32.imm_op} : {bus64.err, bus64.imm_op};
  endfunction

  function automatic logic out_valid_of(input int dw);
    return (dw == 32) ? bus32.out_valid : bus64.out_valid;
  endfunction

  // driver
  task automatic drive(input int dw, input logic v, input logic [31:0] ins,
                       input logic [2:0] src, input logic rdy);
    if (dw == 32) begin
      bus32.in_valid = v; bus32.instr = ins; bus32.imm_src = src; bus32.out_ready = rdy;
    end else begin
      bus64.in_valid = v; bus64.instr = ins; bus64.imm_src = src; bus64.out_ready = rdy;
    end
  endtask

  // scoreboard: occupancy, stall stability, in-order delivery
  task automatic sb(input int idx, input logic in_v, input logic in_r, input logic out_v,
                    input logic out_r, input logic fl, input logic [31:0] ins,
                    input logic [2:0] src, input logic [64:0] act);
    logic [64:0] e;
    chk($sformatf("occ_valid_%0d", idx), 65'(out_v), 65'(q_size(idx) > 0));
    chk($sformatf("occ_ready_%0d", idx), 65'(in_r), 65'(q_size(idx) < 2));
    if (hold[idx]) chk($sformatf("stall_stable_%0d", idx), act, prev[idx]);
    if (fl) begin
      q_clear(idx);
      hold[idx] = 1'b0;
    end else begin
      if (out_v && out_r && q_size(idx) > 0) begin
        e = q_pop(idx);
        chk($sformatf("data_%0d", idx), act, e);
        if (idx == 0) got_q.push_back(act);
      end
      hold[idx] = out_v && !out_r;
      prev[idx] = act;
      if (in_v && in_r) q_push(idx, ref_imm((idx == 0) ? 32 : 64, ins, src));
    end
  endtask

  // one clock: sample at negedge, return 1 unit after the rising edge
  task automatic step();
    @(negedge clk);
    sb(0, bus32.in_valid, bus32.in_ready, bus32.out_valid, bus32.out_ready, flush32,
       bus32.instr, bus32.imm_src, out_of(32));
    sb(1, bus64.in_valid, bus64.in_ready, bus64.out_valid, bus64.out_ready, flush64,
       bus64.instr, bus64.imm_src, out_of(64));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32, 3'b000, 32'hFFF00093, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[1]  = '{32, 3'b011, 32'h123450B7, 64'h0000_0000_1234_5000, 1'b0};
    vecs[2]  = '{32, 3'b100, 32'h001000EF, 64'h0000_0000_0000_0800, 1'b0};
    vecs[3]  = '{32, 3'b001, 32'hFE20AE23, 64'h0000_0000_FFFF_FFFC, 1'b0};
    vecs[4]  = '{32, 3'b010, 32'hFE000EE3, 64'h0000_0000_FFFF_FFFC, 1'b0};
    vecs[5]  = '{32, 3'b110, 32'hFE000EE3, 64'h0,                   1'b1};
    vecs[6]  = '{32, 3'b111, 32'h12345678, 64'h0,                   1'b1};
    vecs[7]  = '{32, 3'b101, 32'h03F00013, 64'h0000_0000_0000_001F, 1'b0};
    vecs[8]  = '{64, 3'b000, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[9]  = '{64, 3'b011, 32'h800000B7, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[10] = '{64, 3'b101, 32'h03F00013, 64'h0000_0000_0000_003F, 1'b0};
    vecs[11] = '{64, 3'b100, 32'h800000EF, 64'hFFFF_FFFF_FFF0_0000, 1'b0};

    rst_n = 1'b0; flush32 = 1'b0; flush64 = 1'b0;
    drive(32, 1'b0, 32'h0, 3'b0, 1'b0);
    drive(64, 1'b0, 32'h0, 3'b0, 1'b0);
    hold[0] = 1'b0; hold[1] = 1'b0; prev[0] = '0; prev[1] = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid32", 65'(bus32.out_valid), 65'(0));
    chk("rst_ready32", 65'(bus32.in_ready), 65'(1));
    chk("rst_data32",  out_of(32), 65'(0));
    chk("rst_state32", 65'(dbg32), 65'(ST_EMPTY));
    chk("rst_valid64", 65'(bus64.out_valid), 65'(0));
    chk("rst_ready64", 65'(bus64.in_ready), 65'(1));
    chk("rst_data64",  out_of(64), 65'(0));
    rst_n = 1'b1;

    // constant vectors: one accept, output exactly one cycle later
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].dw, 1'b1, vecs[i].instr, vecs[i].src, 1'b1);
      step();
      chk($sformatf("vec%0d_valid", i), 65'(out_valid_of(vecs[i].dw)), 65'(1));
      chk($sformatf("vec%0d_imm", i), out_of(vecs[i].dw), {vecs[i].err, vecs[i].imm});
      drive(vecs[i].dw, 1'b0, 32'h0, 3'b0, 1'b1);
      step();
      chk($sformatf("vec%0d_drop", i), 65'(out_valid_of(vecs[i].dw)), 65'(0));
    end

    // back-pressure: A, B stored, C held upstream, then in-order release
    got_q.delete();
    drive(32, 1'b1, 32'h11111037, 3'b011, 1'b0); step();
    drive(32, 1'b1, 32'h22222037, 3'b011, 1'b0); step();
    drive(32, 1'b1, 32'h33333037, 3'b011, 1'b0); step();
    chk("bp_state", 65'(dbg32), 65'(ST_FULL));
    chk("bp_ready", 65'(bus32.in_ready), 65'(0));
    chk("bp_head",  out_of(32), 65'(32'h11111000));
    step();
    chk("bp_hold",  out_of(32), 65'(32'h11111000));
    bus32.out_ready = 1'b1;
    step();
    chk("bp_after_a", out_of(32), 65'(32'h22222000));
    step();
    bus32.in_valid = 1'b0;
    repeat (3) step();
    chk("bp_count", 65'(got_q.size()), 65'(3));
    if (got_q.size() == 3) begin
      chk("bp_order0", got_q[0], 65'(32'h11111000));
      chk("bp_order1", got_q[1], 65'(32'h22222000));
      chk("bp_order2", got_q[2], 65'(32'h33333000));
    end

    // flush while full with a same-cycle input
    drive(32, 1'b1, 32'h0AAAA037, 3'b011, 1'b0); step();
    drive(32, 1'b1, 32'h0BBBB037, 3'b011, 1'b0); step();
    drive(32, 1'b1, 32'h0CCCC037, 3'b011, 1'b0);
    flush32 = 1'b1;
    step();
    flush32 = 1'b0;
    drive(32, 1'b0, 32'h0, 3'b0, 1'b1);
    chk("fl_valid", 65'(bus32.out_valid), 65'(0));
    chk("fl_ready", 65'(bus32.in_ready), 65'(1));
    got_q.delete();
    repeat (3) step();
    chk("fl_nothing", 65'(got_q.size()), 65'(0));

    // asynchronous reset mid-cycle while full
    drive(32, 1'b1, 32'h55555037, 3'b011, 1'b0); step();
    drive(32, 1'b1, 32'h66666037, 3'b011, 1'b0); step();
    chk("ar_full", 65'(dbg32), 65'(ST_FULL));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 65'(bus32.out_valid), 65'(0));
    chk("ar_data",  out_of(32), 65'(0));
    chk("ar_ready", 65'(bus32.in_ready), 65'(1));
    chk("ar_state", 65'(dbg32), 65'(ST_EMPTY));
    q_clear(0); q_clear(1); hold[0] = 1'b0; hold[1] = 1'b0;
    drive(32, 1'b1, 32'h77777037, 3'b011, 1'b1);
    rst_n = 1'b1;
    step();
    chk("ar_first_valid", 65'(bus32.out_valid), 65'(1));
    chk("ar_first_data",  out_of(32), 65'(32'h77777000));
    drive(32, 1'b0, 32'h0, 3'b0, 1'b1);
    step();

    // random traffic on both widths
    for (int c = 0; c < 800; c++) begin
      drive(32, 1'($urandom_range(0, 1)), $urandom(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0);
      drive(64, 1'($urandom_range(0, 1)), $urandom(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0);
      flush32 = ($urandom_range(0, 29) == 0);
      flush64 = ($urandom_range(0, 29) == 0);
      step();
    end
    flush32 = 1'b0; flush64 = 1'b0;
    drive(32, 1'b0, 32'h0, 3'b0, 1'b1);
    drive(64, 1'b0, 32'h0, 3'b0, 1'b1);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
